seven_seg_scanner: RTL and testbench
====================================

# seven_seg_scanner

Time-multiplexed driver for the 4-digit 7-segment display on the receiving end of the scrolling display path. Consumes the 20-bit digit bus (four 5-bit digit codes) and the end-of-number decimal-point flag, and decodes each digit. Scans the anodes one digit at a time with an inter-digit ghosting guard. Input is snapshotted once per frame, so a scroll step never tears mid-frame.

## Interface
- REFRESH_CYCLES, default 100000: clock cycles per digit slot (1 ms at 100 MHz); legal range 2..2^20.
- BLANK_CYCLES, default 4: cycles at the start of each slot with all anodes off; legal 1..REFRESH_CYCLES-1.
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  reset, synchronous and active-low.
- digits_in  input  20  four 5-bit digit codes; [19:15]=digit3 (leftmost) … [4:0]=digit0 (rightmost).
- dp_in  input  1  1 = light decimal point of digit0.
- an  output  4  anodes, active-low, an[i] = digit i.
- seg  output  7  cathodes, active-low, seg[0]=a … seg[6]=g.
- dp  output  1  decimal-point cathode, active-low.
- frame_start  output  1  one-cycle pulse marking the snapshot of a new frame.

## Operation
- State: slot counter cnt (0..REFRESH_CYCLES-1, wraps), digit index idx (0..3, wraps 3->0), shadow registers for digits_in and dp_in, registered outputs.
- Each edge: cnt increments; when cnt==REFRESH_CYCLES-1, cnt<=0 and idx<=idx+1 (mod 4).
- Snapshot: on the edge where cnt==0 && idx==0, the shadow registers load digits_in and dp_in, and frame_start<=1. On all other edges, frame_start<=0 and the shadow registers hold. Input changes at any other time are invisible until the next frame.
- Output registers, computed from pre-edge cnt/idx/shadow:
  - cnt<BLANK_CYCLES: an<=4'b1111, seg<=7'b1111111, dp<=1.
  - otherwise: an<=~(4'b0001<<idx), seg<=decode(shadow code idx), dp<=~(idx==0 && shadow_dp).
- Decode, code bit4=0: hex nibble, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- Decode, code bit4=1: 5'b10001 = minus (seg=7'b0111111); every other code, including 5'b11111, = blank (7'b1111111).
- Scan order: digit0, digit1, digit2, digit3. Exactly one anode is low outside blank windows; no two anodes are ever low together.

## Timing
- Reset (rst_n=0 sampled at an edge): cnt=0, idx=0, shadow codes=5'b11111, shadow_dp=0, an=4'b1111, seg=7'b1111111, dp=1, frame_start=0.
- Reset mid-scan takes effect at that edge regardless of state; the next frame restarts at digit0.
- After reset release, let E0 be the first edge with rst_n=1. E0 snapshots the inputs and sets frame_start=1 (visible after E0 only).
- After edges E0..E(B-1): an=1111. After E(B)..E(R-1): an=1110 showing snapshot digit0. Here B=BLANK_CYCLES, R=REFRESH_CYCLES.
- Frame period: 4·R cycles; frame_start asserts once per frame.
- Latency from the snapshot edge to the first lit segment: B cycles.
- Each digit is lit for R-B cycles per frame.
- Because BLANK_CYCLES>=1, the shadow update at the snapshot edge never reaches a lit output with stale or mixed data.

## Test plan
Use R=8, B=2 for all scenarios.
- Reset values: hold rst_n=0 for 5 cycles with digits_in=20'h0 -> an=1111, seg=1111111, dp=1, frame_start=0 throughout.
- Hex decode: digits_in={0,1,0,2,0,3,0,4} (digits "1234"), dp_in=0, release reset -> frame_start pulses after E0.
  - digit slots in order: an=1110/seg=0011001 ("4"), 1101/0110000 ("3"), 1011/0100100 ("2"), 0111/1111001 ("1").
  - each slot: 2 cycles of 1111 followed by 6 lit cycles.
  - frame_start pulses again at cycle 32.
- Special codes: digit3=5'b10001, digit2=5'b11111, digit1=5'b10110 -> digit3 seg=0111111; digit2 and digit1 seg=1111111.
- Snapshot isolation: change digits_in from "1234" to "ABCD" during digit1's slot -> digits 2–3 still show "1","2". "ABCD" appears from the next frame_start, digit0 = 0100001 ("d").
- Decimal point: dp_in=1 -> dp=0 only during digit0's 6 lit cycles; dp=1 in its blank window and in all other slots.
- Reset mid-scan: assert rst_n=0 for 1 edge during digit2's lit window -> reset values next cycle. The scan restarts at digit0 with frame_start after the first edge with rst_n=1; shadow codes are blank until that snapshot.

Source files
------------

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexed 4-digit 7-segment driver.
// Ports: clk, rst_n (sync, active-low), digits_in[19:0] (four 5-bit
// codes, digit3 leftmost), dp_in (digit0 decimal point);
// an[3:0] anodes, seg[6:0] cathodes a..g, dp cathode (all active-low),
// frame_start pulses on the edge that snapshots a new frame.
module seven_seg_scanner #(
    parameter int REFRESH_CYCLES = 100000,
    parameter int BLANK_CYCLES   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [19:0] digits_in,
    input  logic        dp_in,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_start
);

    localparam int CW = $clog2(REFRESH_CYCLES);
    localparam logic [CW-1:0] LAST  = CW'(REFRESH_CYCLES - 1);
    localparam logic [CW-1:0] BLANK = CW'(BLANK_CYCLES);

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [19:0]   shadow;
    logic          shadow_dp;
    logic [4:0]    cur_code;

    // Code of the digit currently being scanned, from the frame snapshot.
    always_comb begin
        cur_code = shadow[4:0];
        case (idx)
            2'd0: cur_code = shadow[4:0];
            2'd1: cur_code = shadow[9:5];
            2'd2: cur_code = shadow[14:10];
            2'd3: cur_code = shadow[19:15];
            default: cur_code = shadow[4:0];
        endcase
    end

    // Active-low {g,f,e,d,c,b,a}. Codes with bit4 set are either the
    // minus sign (5'b10001) or blank.
    function automatic logic [6:0] decode(input logic [4:0] code);
        logic [6:0] s;
        s = 7'b1111111;
        if (code[4]) begin
            s = (code == 5'b10001) ? 7'b0111111 : 7'b1111111;
        end else begin
            case (code[3:0])
                4'h0: s = 7'b1000000;
                4'h1: s = 7'b1111001;
                4'h2: s = 7'b0100100;
                4'h3: s = 7'b0110000;
                4'h4: s = 7'b0011001;
                4'h5: s = 7'b0010010;
                4'h6: s = 7'b0000010;
                4'h7: s = 7'b1111000;
                4'h8: s = 7'b0000000;
                4'h9: s = 7'b0010000;
                4'hA: s = 7'b0001000;
                4'hB: s = 7'b0000011;
                4'hC: s = 7'b1000110;
                4'hD: s = 7'b0100001;
                4'hE: s = 7'b0000110;
                4'hF: s = 7'b0001110;
                default: s = 7'b1111111;
            endcase
        end
        return s;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt         <= '0;
            idx         <= 2'd0;
            shadow      <= 20'hFFFFF;
            shadow_dp   <= 1'b0;
            an          <= 4'b1111;
            seg         <= 7'b1111111;
            dp          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            if (cnt == LAST) begin
                cnt <= '0;
                idx <= idx + 2'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end

            // Snapshot only at the top of a frame so a scroll step
            // cannot tear the displayed number.
            if (cnt == '0 && idx == 2'd0) begin
                shadow      <= digits_in;
                shadow_dp   <= dp_in;
                frame_start <= 1'b1;
            end else begin
                frame_start <= 1'b0;
            end

            // Blank window at the start of every slot hides the
            // anode switch (ghosting guard) and the shadow reload.
            if (cnt < BLANK) begin
                an  <= 4'b1111;
                seg <= 7'b1111111;
                dp  <= 1'b1;
            end else begin
                an  <= ~(4'b0001 << idx);
                seg <= decode(cur_code);
                dp  <= ~(idx == 2'd0 && shadow_dp);
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: scoreboard bench for seven_seg_scanner.
// Runs with R=8, B=2; an edge-counting model predicts every output cycle.
module tb_seven_seg_scanner;

    localparam int R = 8;
    localparam int B = 2;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fs;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [19:0] digits_in = 20'h0;
    logic        dp_in = 1'b0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_start;

    int total = 0;
    int bad = 0;

    exp_t        sb_q[$];
    int          t = 0;
    logic [19:0] m_digits = 20'hFFFFF;
    logic        m_dp = 1'b0;
    int          fs_seen = 0;

    logic [6:0] hex_tbl [16];
    logic [3:0] an_tbl [4];

    seven_seg_scanner #(
        .REFRESH_CYCLES(R),
        .BLANK_CYCLES(B)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .digits_in(digits_in),
        .dp_in(dp_in),
        .an(an),
        .seg(seg),
        .dp(dp),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at t=%0d time=%0t",
                     tag, got, want, t, $time);
        end
    endtask

    function automatic logic [6:0] m_decode(input logic [4:0] c);
        if (c[4])
            return (c == 5'b10001) ? 7'b0111111 : 7'b1111111;
        return hex_tbl[c[3:0]];
    endfunction

    // One clock: predict the post-edge outputs from the pre-edge model
    // state, queue them, then pop and compare just after the edge.
    task automatic step();
        exp_t e;
        exp_t g;
        int pos;
        int slot;
        logic [4:0] code;
        @(posedge clk);
        if (!rst_n) begin
            e = '{an: 4'b1111, seg: 7'b1111111, dp: 1'b1, fs: 1'b0};
            t = 0;
            m_digits = 20'hFFFFF;
            m_dp = 1'b0;
        end else begin
            pos  = t % R;
            slot = (t / R) % 4;
            code = m_digits[slot*5 +: 5];
            if (pos < B) begin
                e.an = 4'b1111; e.seg = 7'b1111111; e.dp = 1'b1;
            end else begin
                e.an  = an_tbl[slot];
                e.seg = m_decode(code);
                e.dp  = (slot == 0 && m_dp) ? 1'b0 : 1'b1;
            end
            e.fs = (t == 0);
            if (t == 0) begin
                m_digits = digits_in;
                m_dp = dp_in;
            end
            t = (t + 1) % (4 * R);
        end
        sb_q.push_back(e);
        #1;
        g = sb_q.pop_front();
        check("an", 32'(an), 32'(g.an));
        check("seg", 32'(seg), 32'(g.seg));
        check("dp", 32'(dp), 32'(g.dp));
        check("frame_start", 32'(frame_start), 32'(g.fs));
        check("one_anode", 32'($countones(~an) <= 1), 32'd1);
        if (frame_start) fs_seen++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        hex_tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        an_tbl = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

        // Reset held for 5 cycles.
        rst_n = 1'b0;
        digits_in = 20'h0;
        dp_in = 1'b0;
        run(5);

        // "1234", one full frame.
        digits_in = {5'd1, 5'd2, 5'd3, 5'd4};
        rst_n = 1'b1;
        run(4 * R);

        // Special codes: minus, blank 11111, blank 10110, "4".
        digits_in = {5'b10001, 5'b11111, 5'b10110, 5'd4};
        run(4 * R);

        // Snapshot isolation: change mid-frame during digit1's slot.
        digits_in = {5'd1, 5'd2, 5'd3, 5'd4};
        run(R + 3);
        digits_in = {5'hA, 5'hB, 5'hC, 5'hD};
        dp_in = 1'b1;
        run(3 * R - 3);

        // "ABCD" with decimal point, then reset during digit2 lit.
        run(2 * R + B + 1);
        rst_n = 1'b0;
        run(1);
        rst_n = 1'b1;
        run(4 * R + R);

        check("frame_count", 32'(fs_seen), 32'd6);
        check("queue_empty", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
